mic1_main_memory: RTL
=====================

Name: mic1_main_memory

Overview:
- Responder for the Mic-1 core's main-memory interface.
- Services word reads and writes addressed by MAR, and byte instruction fetches addressed by PC, from one unified word array.
- Contains a byte-stream program loader that fills the array after reset and holds the core in reset until loading completes.
- Sits beside the core in the top level; connects to its mem_* ports and drives its resetn.

Parameters:
- MEM_WORDS, 4096: array depth in 32-bit words; power of two.
- MMIO_WORD_ADDR, 32'h3FFF_FFFF: word address of the output port. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  32  word address (MAR).
- mem_wdata  in  32  write data (MDR).
- mem_rdata  out  32  read data.
- mem_read  in  1  read strobe.
- mem_write  in  1  write strobe.
- mem_addr_instr  in  32  byte address (PC).
- mem_rd_instr  out  8  fetched byte.
- mem_fetch  in  1  fetch strobe.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  final loader byte; qualified by ld_valid.
- ld_ready  out  1  loader can accept a byte.
- cpu_resetn  out  1  active-low reset to the core.
- err_sticky  out  1  an out-of-range access has occurred.
- err_count  out  16  count of out-of-range accesses; saturates at 16'hFFFF.
- ld_overflow  out  1  the loader dropped bytes past the end of the array.

Behaviour:
- Reset (sampled at posedge while reset=1):
  - state=LOAD, ld_ptr=0, byte_cnt=0, assembly register=0.
  - cpu_resetn=0, ld_ready=0 during reset, then 1 from the first cycle in LOAD.
  - err_sticky=0, err_count=0, ld_overflow=0.
  - Array contents are NOT cleared.
- States:
  - LOAD: accepts loader bytes; core strobes are ignored (no writes, outputs 0, no error counting).
  - RUN: services core strobes; ld_ready=0.
- Loader handshake:
  - A byte transfers on a posedge where ld_valid & ld_ready.
  - Bytes are packed big-endian: the first byte goes to [31:24].
  - On the 4th byte: write the word to array[ld_ptr], ld_ptr++, byte_cnt=0.
  - On ld_last: write the partial word zero-padded in the low bytes (if byte_cnt>0 including this byte), then go to RUN.
  - If ld_ptr==MEM_WORDS, bytes are accepted and discarded and ld_overflow is set.
  - cpu_resetn is a registered output: it goes 1 on the cycle after the LOAD->RUN edge.
- Reads:
  - Same-cycle, combinational from registered addresses: mem_rdata = mem_read ? array[mem_addr] : 0.
  - The core samples mem_rdata on the posedge that ends the strobe cycle.
- Fetch:
  - mem_rd_instr = mem_fetch ? byte mem_addr_instr[1:0] of array[mem_addr_instr>>2] : 8'h00.
  - Byte 0 is [31:24].
- Writes: when mem_write=1, mem_wdata is committed to array[mem_addr] at the posedge.
- Simultaneous read and write to the same address: the read returns the OLD word; the new word is visible from the next cycle.
- Read and fetch may be active in the same cycle; both are serviced independently.
- Out of range (mem_addr>=MEM_WORDS, or mem_addr_instr>=4*MEM_WORDS, in RUN):
  - The read or fetch returns 0; the write is dropped.
  - err_count increments by 1 per offending strobe per cycle, up to +3 per cycle, saturating.
  - err_sticky=1.
- Reset asserted mid-load or mid-run:
  - Returns to LOAD with ld_ptr=0 and cpu_resetn=0 at that edge.
  - A write strobed in that same cycle is not committed.

Optional Feature:
- Macro: MIC1_MEM_MMIO_EN.
- Defined:
  - Extra outputs io_out[31:0] (reset 0) and io_strobe (1-cycle pulse).
  - A write to MMIO_WORD_ADDR in RUN loads io_out with mem_wdata and pulses io_strobe the next cycle; the array is not written and no error is counted.
  - A read of MMIO_WORD_ADDR returns io_out.
- Not defined: the ports are absent, and MMIO_WORD_ADDR is an ordinary out-of-range address.

Test Plan:
- Load: reset, then stream bytes 01 02 03 04 05 with ld_last on 05.
  - array[0]=32'h01020304, array[1]=32'h05000000.
  - cpu_resetn rises 1 cycle after the ld_last handshake; ld_ready=0 afterwards.
- Fetch: after that load, fetch PC=0..4 -> 01, 02, 03, 04, 05; with mem_fetch=0 -> 00.
- Read-during-write: array[7]=32'hAAAA_0000; same cycle mem_read=mem_write=1, addr 7, wdata 32'h1234_5678.
  - mem_rdata=32'hAAAA_0000 in that cycle.
  - The next cycle's read gives 32'h1234_5678.
- Out of range: read at MEM_WORDS and write at MEM_WORDS+5.
  - rdata=0, no array change, err_count=2, err_sticky=1.
  - Preload err_count near 16'hFFFF -> it stays 16'hFFFF.
- Overflow and reset: load 4*MEM_WORDS+3 bytes -> ld_overflow=1, last array word unchanged by the extra bytes.
  - Assert reset mid-stream -> cpu_resetn=0, ld_ptr restarts, prior array contents retained.
- MMIO (macro on): write 32'hDEAD_BEEF to MMIO_WORD_ADDR -> io_out=32'hDEAD_BEEF, single io_strobe pulse, err_count unchanged.

Source files
------------

// File: rtl/mic1_main_memory_if.sv
`default_nettype none
//==============================================================================
// Module  : mic1_main_memory_if
// Brief   : Mic-1 core memory bus (MAR/MDR word port, PC byte-fetch port)
//           bundled with the program-loader byte stream.
// Revision: 1.0 - initial release
//==============================================================================
interface mic1_main_memory_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr_instr;
    logic [7:0]  mem_rd_instr;
    logic        mem_fetch;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        output mem_addr_instr, mem_fetch,
        output ld_valid, ld_data, ld_last,
        input  mem_rdata, mem_rd_instr, ld_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_addr_instr, mem_fetch,
        input  ld_valid, ld_data, ld_last,
        output mem_rdata, mem_rd_instr, ld_ready
    );
endinterface
`default_nettype wire

// File: rtl/mic1_main_memory.sv
`default_nettype none
//==============================================================================
// Module  : mic1_main_memory
// Brief   : Unified word/byte main memory for the Mic-1 core with a big-endian
//           byte-stream loader that holds the core in reset until loading ends.
//           Optional memory-mapped output port: define MIC1_MEM_MMIO_EN.
// Revision: 1.0 - initial release
//==============================================================================
module mic1_main_memory #(
    parameter int unsigned MEM_WORDS = 4096
`ifdef MIC1_MEM_MMIO_EN
    ,
    parameter logic [31:0] MMIO_WORD_ADDR = 32'h3FFF_FFFF
`endif
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mic1_main_memory_if.slave   bus,
    output logic                cpu_resetn,
    output logic                err_sticky,
    output logic [15:0]         err_count,
    output logic                ld_overflow
`ifdef MIC1_MEM_MMIO_EN
    ,
    output logic [31:0]         io_out,
    output logic                io_strobe
`endif
);

    localparam int c_aw = $clog2(MEM_WORDS);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [31:0]     r_mem [MEM_WORDS];
    logic [c_aw:0]   r_ld_ptr;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_asm;
    logic            r_cpu_resetn;
    logic            r_err_sticky;
    logic [15:0]     r_err_count;
    logic            r_ld_overflow;

    logic            w_run;
    logic            w_mmio;
    logic            w_addr_oob;
    logic            w_fe_oob;
    logic [c_aw-1:0] w_rd_idx;
    logic [c_aw-1:0] w_fe_idx;
    logic [31:0]     w_fe_word;
    logic [31:0]     w_fe_shift;
    logic            w_rd_err;
    logic            w_wr_err;
    logic            w_fe_err;
    logic [1:0]      w_err_inc;
    logic [16:0]     w_err_sum;
    logic            w_core_wr;
    logic            w_ld_fire;
    logic            w_ld_full;
    logic            w_ld_flush;
    logic [31:0]     w_ld_word;

    assign w_run      = (r_state == ST_RUN);
    assign w_addr_oob = |bus.mem_addr[31:c_aw];
    assign w_fe_oob   = |bus.mem_addr_instr[31:c_aw+2];
    assign w_rd_idx   = bus.mem_addr[c_aw-1:0];
    assign w_fe_idx   = bus.mem_addr_instr[c_aw+1:2];

`ifdef MIC1_MEM_MMIO_EN
    logic        r_io_strobe;
    logic [31:0] r_io_out;
    logic        w_io_wr;

    assign w_mmio    = (bus.mem_addr == MMIO_WORD_ADDR);
    assign w_io_wr   = w_run & bus.mem_write & w_mmio;
    assign io_out    = r_io_out;
    assign io_strobe = r_io_strobe;
`else
    assign w_mmio    = 1'b0;
`endif

    // The MMIO word takes priority over array decode and is never an error.
    assign w_rd_err  = w_run & bus.mem_read  & w_addr_oob & ~w_mmio;
    assign w_wr_err  = w_run & bus.mem_write & w_addr_oob & ~w_mmio;
    assign w_fe_err  = w_run & bus.mem_fetch & w_fe_oob;
    assign w_err_inc = {1'b0, w_rd_err} + {1'b0, w_wr_err} + {1'b0, w_fe_err};
    assign w_err_sum = {1'b0, r_err_count} + {15'h0, w_err_inc};
    assign w_core_wr = w_run & bus.mem_write & ~w_addr_oob & ~w_mmio;

    assign bus.ld_ready = ~w_run & ~reset;
    assign w_ld_fire    = bus.ld_valid & bus.ld_ready;
    assign w_ld_full    = r_ld_ptr[c_aw];
    assign w_ld_flush   = (r_byte_cnt == 2'd3) | bus.ld_last;
    // Big-endian packing: byte n of a word lands at bits [31-8n -: 8].
    assign w_ld_word    = r_asm | ({24'h0, bus.ld_data} << {~r_byte_cnt, 3'b000});

    always_comb begin
        bus.mem_rdata = 32'h0;
        if (w_run && bus.mem_read) begin
`ifdef MIC1_MEM_MMIO_EN
            if (w_mmio) begin
                bus.mem_rdata = r_io_out;
            end else
`endif
            if (!w_addr_oob) begin
                bus.mem_rdata = r_mem[w_rd_idx];
            end
        end
    end

    assign w_fe_word  = r_mem[w_fe_idx];
    assign w_fe_shift = w_fe_word >> {~bus.mem_addr_instr[1:0], 3'b000};
    assign bus.mem_rd_instr = (w_run && bus.mem_fetch && !w_fe_oob) ? w_fe_shift[7:0] : 8'h00;

    // Array contents survive reset; only the write enables are gated by it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_ld_fire && w_ld_flush && !w_ld_full) begin
                r_mem[r_ld_ptr[c_aw-1:0]] <= w_ld_word;
            end else if (w_core_wr) begin
                r_mem[w_rd_idx] <= bus.mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_LOAD;
            r_ld_ptr      <= '0;
            r_byte_cnt    <= 2'd0;
            r_asm         <= 32'h0;
            r_cpu_resetn  <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_count   <= 16'h0;
            r_ld_overflow <= 1'b0;
`ifdef MIC1_MEM_MMIO_EN
            r_io_out      <= 32'h0;
            r_io_strobe   <= 1'b0;
`endif
        end else begin
            r_cpu_resetn <= w_run;
            if (w_ld_fire) begin
                if (w_ld_full) begin
                    r_ld_overflow <= 1'b1;
                end
                if (w_ld_flush) begin
                    r_asm      <= 32'h0;
                    r_byte_cnt <= 2'd0;
                    if (!w_ld_full) begin
                        r_ld_ptr <= r_ld_ptr + {{c_aw{1'b0}}, 1'b1};
                    end
                end else begin
                    r_asm      <= w_ld_word;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                if (bus.ld_last) begin
                    r_state <= ST_RUN;
                end
            end
            if (w_err_inc != 2'd0) begin
                r_err_sticky <= 1'b1;
                r_err_count  <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            end
`ifdef MIC1_MEM_MMIO_EN
            r_io_strobe <= w_io_wr;
            if (w_io_wr) begin
                r_io_out <= bus.mem_wdata;
            end
`endif
        end
    end

    assign cpu_resetn  = r_cpu_resetn;
    assign err_sticky  = r_err_sticky;
    assign err_count   = r_err_count;
    assign ld_overflow = r_ld_overflow;

endmodule
`default_nettype wire
